// File: rtl/wb_arbiter_pkg.sv
// Shared core defines for the writeback path: register-file geometry,
// the zero register/word constants and the writeback payload types.
package wb_arbiter_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;
   localparam int NUM_REGS   = 1 << REG_ADDR_W;

   localparam logic [REG_ADDR_W-1:0] ZERO_REG_ADDR = '0;
   localparam logic [REG_DATA_W-1:0] ZERO_WORD     = '0;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [REG_DATA_W-1:0] reg_data_t;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_ALU,
      SRC_LSU
   } wb_src_e;

   typedef struct packed {
      logic      en;
      reg_addr_t addr;
      reg_data_t data;
   } wb_write_t;

   // x0 is hardwired to zero, so a result aimed at it never reaches the file.
   function automatic logic writes_reg(input reg_addr_t addr);
      return addr != ZERO_REG_ADDR;
   endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set when a
// long-latency op issues and cleared when its result is written back.
module wb_scoreboard
   import wb_arbiter_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  set_en,
   input  logic [REG_ADDR_W-1:0] set_addr,
   input  logic                  clr_en,
   input  logic [REG_ADDR_W-1:0] clr_addr,
   output logic [NUM_REGS-1:0]   pending
);

   logic [NUM_REGS-1:0] pending_reg;
   logic [NUM_REGS-1:0] pending_next;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_bit
         if (gi == 0) begin : g_zero
            assign pending_next[gi] = 1'b0;
         end else begin : g_reg
            logic set_hit;
            logic clr_hit;
            assign set_hit = set_en && (set_addr == REG_ADDR_W'(gi));
            assign clr_hit = clr_en && (clr_addr == REG_ADDR_W'(gi));
            // A fresh issue outranks a writeback retiring the older op.
            assign pending_next[gi] = set_hit || (pending_reg[gi] && !clr_hit);
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending_reg <= '0;
      end else begin
         pending_reg <= pending_next;
      end
   end

   assign pending = pending_reg;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and long-latency results into one registered
// register-file write port, with ALU priority and LSU starvation relief.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  alu_valid,
   output logic                  alu_ready,
   input  logic [REG_ADDR_W-1:0] alu_addr,
   input  logic [REG_DATA_W-1:0] alu_data,
   input  logic                  lsu_valid,
   output logic                  lsu_ready,
   input  logic [REG_ADDR_W-1:0] lsu_addr,
   input  logic [REG_DATA_W-1:0] lsu_data,
   input  logic                  issue_en,
   input  logic [REG_ADDR_W-1:0] issue_addr,
   output logic                  wr_en,
   output logic [REG_ADDR_W-1:0] wr_addr,
   output logic [REG_DATA_W-1:0] wr_data,
   output logic [NUM_REGS-1:0]   pending
);

   localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

   logic [CNT_W-1:0] starve_cnt_reg;
   logic [CNT_W-1:0] starve_cnt_next;
   logic             lsu_prio;
   wb_src_e          src_sel;
   wb_write_t        wr_reg;
   wb_write_t        wr_next;

   assign lsu_prio = (starve_cnt_reg == CNT_W'(STARVE_MAX));

   // Readies look only at valids and the counter so neither source sees a data path.
   always_comb begin
      alu_ready = 1'b0;
      lsu_ready = 1'b0;
      src_sel   = SRC_NONE;
      if (rst_n) begin
         if (lsu_prio) begin
            lsu_ready = 1'b1;
            alu_ready = !lsu_valid;
         end else begin
            alu_ready = 1'b1;
            lsu_ready = !alu_valid;
         end
      end
      if (alu_valid && alu_ready) begin
         src_sel = SRC_ALU;
      end else if (lsu_valid && lsu_ready) begin
         src_sel = SRC_LSU;
      end
   end

   always_comb begin
      starve_cnt_next = starve_cnt_reg;
      if (!lsu_valid || (src_sel == SRC_LSU)) begin
         starve_cnt_next = '0;
      end else if (!lsu_prio) begin
         starve_cnt_next = starve_cnt_reg + 1'b1;
      end
   end

   always_comb begin
      wr_next    = wr_reg;
      wr_next.en = 1'b0;
      case (src_sel)
         SRC_ALU: wr_next = '{en: writes_reg(alu_addr), addr: alu_addr, data: alu_data};
         SRC_LSU: wr_next = '{en: writes_reg(lsu_addr), addr: lsu_addr, data: lsu_data};
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_reg         <= '{en: 1'b0, addr: ZERO_REG_ADDR, data: ZERO_WORD};
         starve_cnt_reg <= '0;
      end else begin
         wr_reg         <= wr_next;
         starve_cnt_reg <= starve_cnt_next;
      end
   end

   assign wr_en   = wr_reg.en;
   assign wr_addr = wr_reg.addr;
   assign wr_data = wr_reg.data;

   wb_scoreboard u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en   (issue_en),
      .set_addr (issue_addr),
      .clr_en   (src_sel == SRC_LSU),
      .clr_addr (lsu_addr),
      .pending  (pending)
   );

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: a behavioural model checked every cycle plus directed
// scenarios with hand-computed literal expectations.
module tb_wb_arbiter;
   import wb_arbiter_pkg::*;

   localparam int STARVE_MAX = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        alu_valid = 1'b0;
   logic        alu_ready;
   logic [4:0]  alu_addr = '0;
   logic [31:0] alu_data = '0;
   logic        lsu_valid = 1'b0;
   logic        lsu_ready;
   logic [4:0]  lsu_addr = '0;
   logic [31:0] lsu_data = '0;
   logic        issue_en = 1'b0;
   logic [4:0]  issue_addr = '0;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [31:0] pending;

   always #5 clk = ~clk;

   wb_arbiter #(.STARVE_MAX(STARVE_MAX)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .alu_valid  (alu_valid),
      .alu_ready  (alu_ready),
      .alu_addr   (alu_addr),
      .alu_data   (alu_data),
      .lsu_valid  (lsu_valid),
      .lsu_ready  (lsu_ready),
      .lsu_addr   (lsu_addr),
      .lsu_data   (lsu_data),
      .issue_en   (issue_en),
      .issue_addr (issue_addr),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .pending    (pending)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // Model state: stall streak length, pending set, and the write owed next cycle.
   int        m_starve = 0;
   bit [31:0] m_pend = '0;
   bit        m_wr_en = 1'b0;
   bit [4:0]  m_wr_addr = '0;
   bit [31:0] m_wr_data = '0;
   bit        chk_en = 1'b0;
   bit        m_ar, m_lr;

   function automatic bit exp_alu_ready();
      if (!rst_n) return 1'b0;
      return (m_starve >= STARVE_MAX) ? !lsu_valid : 1'b1;
   endfunction

   function automatic bit exp_lsu_ready();
      if (!rst_n) return 1'b0;
      return (m_starve >= STARVE_MAX) ? 1'b1 : !alu_valid;
   endfunction

   always @(posedge clk) begin
      m_ar = exp_alu_ready();
      m_lr = exp_lsu_ready();
      if (!rst_n) begin
         m_starve  = 0;
         m_pend    = '0;
         m_wr_en   = 1'b0;
         m_wr_addr = '0;
         m_wr_data = '0;
      end else begin
         m_wr_en = 1'b0;
         if (alu_valid && m_ar) begin
            m_wr_en   = (alu_addr != 0);
            m_wr_addr = alu_addr;
            m_wr_data = alu_data;
         end else if (lsu_valid && m_lr) begin
            m_wr_en   = (lsu_addr != 0);
            m_wr_addr = lsu_addr;
            m_wr_data = lsu_data;
            m_pend[lsu_addr] = 1'b0;
         end
         if (lsu_valid && !m_lr) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
         else m_starve = 0;
         if (issue_en && issue_addr != 0) m_pend[issue_addr] = 1'b1;
      end
      chk_en = 1'b1;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("alu_ready", {31'b0, alu_ready}, {31'b0, exp_alu_ready()});
         chk("lsu_ready", {31'b0, lsu_ready}, {31'b0, exp_lsu_ready()});
         chk("wr_en", {31'b0, wr_en}, {31'b0, m_wr_en});
         if (m_wr_en) begin
            chk("wr_addr", {27'b0, wr_addr}, {27'b0, m_wr_addr});
            chk("wr_data", wr_data, m_wr_data);
            $display("txn @%0t: wr x%0d <= 0x%08h", $time, wr_addr, wr_data);
         end
         chk("pending", pending, m_pend);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit a;
      bit l;
   } vec_t;
   vec_t vecs[9];

   initial begin
      // Reset with transfers presented: readies stay low, nothing is written.
      rst_n = 1'b0; alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'hDEAD_BEEF;
      lsu_valid = 1'b1; lsu_addr = 5'd4; lsu_data = 32'h4444_4444;
      #1;
      chk("rst_alu_ready", {31'b0, alu_ready}, 32'd0);
      chk("rst_lsu_ready", {31'b0, lsu_ready}, 32'd0);
      cyc(); cyc();
      chk("rst_wr_en", {31'b0, wr_en}, 32'd0);
      chk("rst_wr_addr", {27'b0, wr_addr}, 32'd0);
      chk("rst_wr_data", wr_data, 32'd0);
      chk("rst_pending", pending, 32'd0);
      rst_n = 1'b1; alu_valid = 1'b0; lsu_valid = 1'b0;
      cyc();
      chk("post_rst_wr_en", {31'b0, wr_en}, 32'd0);

      // ALU write to x5 appears the next cycle for exactly one cycle.
      alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h0000_1234;
      #1 chk("alu5_ready", {31'b0, alu_ready}, 32'd1);
      cyc();
      chk("alu5_wr_en", {31'b0, wr_en}, 32'd1);
      chk("alu5_wr_addr", {27'b0, wr_addr}, 32'd5);
      chk("alu5_wr_data", wr_data, 32'h0000_1234);
      alu_valid = 1'b0;
      cyc();
      chk("alu5_held_once", {31'b0, wr_en}, 32'd0);

      // Both valid: LSU stalls two cycles, wins the third, writes in the fourth.
      alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h0000_00A1;
      lsu_valid = 1'b1; lsu_addr = 5'd2; lsu_data = 32'h0000_00B2;
      for (int c = 1; c <= 3; c++) begin
         #1 chk($sformatf("starve_lsu_ready_c%0d", c), {31'b0, lsu_ready}, (c == 3) ? 32'd1 : 32'd0);
         if (c == 3) chk("starve_alu_ready_c3", {31'b0, alu_ready}, 32'd0);
         cyc();
      end
      chk("starve_wr_en_c4", {31'b0, wr_en}, 32'd1);
      chk("starve_wr_addr_c4", {27'b0, wr_addr}, 32'd2);
      chk("starve_wr_data_c4", wr_data, 32'h0000_00B2);
      #1 chk("starve_lsu_ready_c4", {31'b0, lsu_ready}, 32'd0);
      alu_valid = 1'b0; lsu_valid = 1'b0;
      cyc();

      // Issue to x7, retire it four cycles later.
      issue_en = 1'b1; issue_addr = 5'd7;
      cyc();
      issue_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("pend7_c%0d", i + 1), {31'b0, pending[7]}, 32'd1);
         if (i == 3) begin
            lsu_valid = 1'b1; lsu_addr = 5'd7; lsu_data = 32'h0000_0077;
         end
         cyc();
      end
      lsu_valid = 1'b0;
      chk("pend7_cleared", {31'b0, pending[7]}, 32'd0);
      chk("lsu7_wr_addr", {27'b0, wr_addr}, 32'd7);

      // Same-cycle issue and retire of x9 leaves it pending.
      issue_en = 1'b1; issue_addr = 5'd9;
      cyc();
      chk("pend9_set", {31'b0, pending[9]}, 32'd1);
      lsu_valid = 1'b1; lsu_addr = 5'd9; lsu_data = 32'h0000_0099;
      cyc();
      issue_en = 1'b0; lsu_valid = 1'b0;
      chk("pend9_kept", {31'b0, pending[9]}, 32'd1);
      chk("lsu9_wr_en", {31'b0, wr_en}, 32'd1);

      // x0 writes are accepted but suppressed; x0 never becomes pending.
      alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hFFFF_FFFF;
      issue_en = 1'b1; issue_addr = 5'd0;
      #1 chk("x0_alu_ready", {31'b0, alu_ready}, 32'd1);
      cyc();
      alu_valid = 1'b0; issue_en = 1'b0;
      chk("x0_wr_en", {31'b0, wr_en}, 32'd0);
      chk("x0_pending", pending, 32'h0000_0200);

      // Priority walk, including LSU dropping while it holds priority.
      vecs = '{'{1, 1}, '{1, 1}, '{1, 0}, '{0, 1}, '{1, 1}, '{0, 0}, '{1, 1}, '{1, 1}, '{1, 1}};
      lsu_addr = 5'd9; lsu_data = 32'h0000_005A;
      for (int v = 0; v < 9; v++) begin
         alu_valid = vecs[v].a; lsu_valid = vecs[v].l;
         alu_addr = 5'(10 + v); alu_data = 32'h100 + 32'(v);
         if (v == 2) begin
            #1 chk("prio_drop_alu_ready", {31'b0, alu_ready}, 32'd1);
            chk("prio_drop_lsu_ready", {31'b0, lsu_ready}, 32'd1);
         end
         cyc();
      end
      alu_valid = 1'b0; lsu_valid = 1'b0;
      chk("walk_pending", pending, 32'd0);

      // Reset in the middle of a stall with x7 pending.
      issue_en = 1'b1; issue_addr = 5'd7;
      cyc();
      issue_en = 1'b0;
      chk("pre_rst_pending", pending, 32'h0000_0080);
      alu_valid = 1'b1; alu_addr = 5'd12; alu_data = 32'h0000_0C0C;
      lsu_valid = 1'b1; lsu_addr = 5'd7; lsu_data = 32'h0000_0707;
      cyc();
      rst_n = 1'b0;
      #1 chk("mid_rst_lsu_ready", {31'b0, lsu_ready}, 32'd0);
      cyc();
      rst_n = 1'b1;
      chk("mid_rst_wr_en", {31'b0, wr_en}, 32'd0);
      chk("mid_rst_pending", pending, 32'd0);
      for (int c = 1; c <= 3; c++) begin
         #1 chk($sformatf("restart_lsu_ready_c%0d", c), {31'b0, lsu_ready}, (c == 3) ? 32'd1 : 32'd0);
         cyc();
      end
      chk("restart_wr_addr", {27'b0, wr_addr}, 32'd7);
      alu_valid = 1'b0; lsu_valid = 1'b0;
      cyc(); cyc();
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule
